// File: rtl/proc_defs.sv
// Shared processor definitions: opcodes, ALU function codes, instruction field
// layout and the fetch-stage state encoding used by fetch and control.
package proc_defs;

    localparam int DEFAULT_PC_WIDTH = 12;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    typedef enum logic [4:0] {
        FN_ADD = 5'd0,
        FN_SUB = 5'd1,
        FN_AND = 5'd2,
        FN_OR  = 5'd3,
        FN_SLL = 5'd4,
        FN_SRA = 5'd5
    } func_e;

    localparam int OPCODE_LSB = 27;
    localparam int RD_LSB     = 22;
    localparam int RS_LSB     = 17;
    localparam int RT_LSB     = 12;
    localparam int SHAMT_LSB  = 7;
    localparam int FUNC_LSB   = 2;
    localparam int IMM_MSB    = 16;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_insn_fields.sv
// Pure combinational instruction slicer: splits a 32-bit word into its register,
// opcode and function fields and sign-extends the 17-bit immediate.
module insn_fields
    import proc_defs::*;
(
    input  logic [31:0] word_i,
    output logic [4:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  shamt_o,
    output logic [4:0]  func_o,
    output logic [31:0] imm_sext_o
);

    assign opcode_o   = word_i[OPCODE_LSB +: 5];
    assign rd_o       = word_i[RD_LSB +: 5];
    assign rs_o       = word_i[RS_LSB +: 5];
    assign rt_o       = word_i[RT_LSB +: 5];
    assign shamt_o    = word_i[SHAMT_LSB +: 5];
    assign func_o     = word_i[FUNC_LSB +: 5];
    assign imm_sext_o = {{15{word_i[IMM_MSB]}}, word_i[IMM_MSB:0]};

    // The two low bits carry no field in this encoding.
    logic [1:0] unusedLo;
    assign unusedLo = word_i[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the 1-cycle-latency ROM, registers
// the returned word and handles downstream stall and branch redirect with squash.
module fetch_unit
    import proc_defs::*;
#(
    parameter int                  PC_WIDTH = DEFAULT_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_q,
    output logic                insn_valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_plus1,
    output logic [4:0]          opcode,
    output logic [4:0]          rd,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          shamt,
    output logic [4:0]          alu_in,
    output logic [31:0]         imm_sext
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] fa_q;
    logic [PC_WIDTH-1:0] pcout_q;
    logic                fv_q;
    logic [31:0]         instr_q;
    fetch_state_e        state_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (!stall) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // While stalled the ROM re-reads the in-flight address, so its word is
    // still on imem_q when the stall releases and no skid buffer is needed.
    assign imem_addr = (stall && !redirect) ? fa_q : pc_q;

    // The decoded-instruction valid bit lives in the state: FILL means empty,
    // RUN and HOLD both mean instr_q holds a real instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            fa_q    <= RESET_PC;
            fv_q    <= 1'b0;
            instr_q <= '0;
            pcout_q <= '0;
            state_q <= FILL;
        end else if (redirect) begin
            pc_q    <= pc_d;
            fa_q    <= pc_q;
            fv_q    <= 1'b0;
            state_q <= FILL;
        end else if (!stall) begin
            pc_q    <= pc_d;
            fa_q    <= pc_q;
            fv_q    <= 1'b1;
            instr_q <= imem_q;
            pcout_q <= fa_q;
            state_q <= fv_q ? RUN : FILL;
        end else if (state_q == RUN) begin
            state_q <= HOLD;
        end
    end

    assign insn_valid = (state_q != FILL);
    assign instr      = instr_q;
    assign pc_out     = pcout_q;
    assign pc_plus1   = pcout_q + 1'b1;

    insn_fields u_fields (
        .word_i     (instr_q),
        .opcode_o   (opcode),
        .rd_o       (rd),
        .rs_o       (rs),
        .rt_o       (rt),
        .shamt_o    (shamt),
        .func_o     (alu_in),
        .imm_sext_o (imm_sext)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: stimulus pushes per-cycle control records,
// a monitor replays them against an architectural instruction-stream model.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic [11:0] imem_addr;
    logic [31:0] imem_q;
    logic        insn_valid;
    logic [31:0] instr;
    logic [11:0] pc_out;
    logic [11:0] pc_plus1;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [4:0]  alu_in;
    logic [31:0] imm_sext;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] rom [4096];

    typedef struct packed {
        logic        rst;
        logic        stl;
        logic        redir;
        logic [11:0] target;
    } ctlRec_t;

    ctlRec_t ctlQ[$];

    fetch_unit #(.PC_WIDTH(12), .RESET_PC(12'd0)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .insn_valid  (insn_valid),
        .instr       (instr),
        .pc_out      (pc_out),
        .pc_plus1    (pc_plus1),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .rt          (rt),
        .shamt       (shamt),
        .alu_in      (alu_in),
        .imm_sext    (imm_sext)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clock) imem_q <= rom[imem_addr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] refImm(input logic [31:0] w);
        logic [31:0] low;
        low = w & 32'h0001_FFFF;
        return (((w >> 16) & 32'd1) != 0) ? (low | 32'hFFFE_0000) : low;
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic rdr, input logic [11:0] t);
        @(negedge clock);
        reset       = r;
        stall       = s;
        redirect    = rdr;
        redirect_pc = t;
        ctlQ.push_back('{r, s, rdr, t});
    endtask

    // Run unstalled until pc_out shows p with a valid instruction; on return the
    // bench sits inside that cycle, before its negedge.
    task automatic runUntilPc(input logic [11:0] p);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
            @(posedge clock);
            #1;
            found = insn_valid && (pc_out == p);
        end
        checkOutput($sformatf("reach_pc_%0h", p), {31'd0, found}, 32'd1);
    endtask

    // Monitor: the expected stream is sequential from the reset PC or from each
    // redirect target; an instruction becomes visible two unstalled edges after
    // the stream (re)starts, and is consumed on an edge that is not a plain stall.
    initial begin
        ctlRec_t     rec;
        int          normalEdges;
        logic [11:0] expPc;
        logic [31:0] w;
        normalEdges = 0;
        expPc = 12'd0;
        forever begin
            @(negedge clock);
            #1;
            if (ctlQ.size() > 0) begin
                rec = ctlQ.pop_front();
                if (rec.rst) begin
                    normalEdges = 0;
                    expPc = 12'd0;
                end else begin
                    checkOutput("insn_valid", {31'd0, insn_valid}, {31'd0, normalEdges >= 2});
                    if (normalEdges >= 2 && (!rec.stl || rec.redir)) begin
                        w = rom[expPc];
                        checkOutput("pc_out", {20'd0, pc_out}, {20'd0, expPc});
                        checkOutput("instr", instr, w);
                        checkOutput("pc_plus1", {20'd0, pc_plus1}, (expPc + 32'd1) % 32'd4096);
                        checkOutput("opcode", {27'd0, opcode}, w >> 27);
                        checkOutput("rd", {27'd0, rd}, (w >> 22) & 32'h1F);
                        checkOutput("rs", {27'd0, rs}, (w >> 17) & 32'h1F);
                        checkOutput("rt", {27'd0, rt}, (w >> 12) & 32'h1F);
                        checkOutput("shamt", {27'd0, shamt}, (w >> 7) & 32'h1F);
                        checkOutput("alu_in", {27'd0, alu_in}, (w >> 2) & 32'h1F);
                        checkOutput("imm_sext", imm_sext, refImm(w));
                        expPc = expPc + 12'd1;
                    end
                    if (rec.redir) begin
                        expPc = rec.target;
                        normalEdges = 0;
                    end else if (!rec.stl && normalEdges < 2) begin
                        normalEdges++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = (i < 64) ? i * 32'h11 : $urandom;
        end
        rom[20] = 32'h28C4_0007;
        rom[21] = 32'hF801_FFFF;
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 12'd0;

        applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
        #1;
        checkOutput("rst_valid", {31'd0, insn_valid}, 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_pc_out", {20'd0, pc_out}, 32'd0);
        checkOutput("rst_imm", imm_sext, 32'd0);
        checkOutput("rst_opcode", {27'd0, opcode}, 32'd0);
        checkOutput("rst_imem_addr", {20'd0, imem_addr}, 32'd0);

        // Reset falls in cycle 0; first instruction appears in cycle 2.
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
        @(posedge clock); #1;
        checkOutput("cyc1_valid", {31'd0, insn_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
        @(posedge clock); #1;
        checkOutput("cyc2_valid", {31'd0, insn_valid}, 32'd1);
        checkOutput("cyc2_pc", {20'd0, pc_out}, 32'd0);
        checkOutput("cyc2_instr", instr, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
        @(posedge clock); #1;
        checkOutput("cyc3_pc", {20'd0, pc_out}, 32'd1);
        checkOutput("cyc3_instr", instr, 32'h11);

        runUntilPc(12'd5);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 12'd0);
            #1;
            checkOutput("stall_imem_addr", {20'd0, imem_addr}, 32'd6);
            checkOutput("stall_pc_out", {20'd0, pc_out}, 32'd5);
        end
        runUntilPc(12'd10);
        applyStimulus(1'b0, 1'b0, 1'b1, 12'h100);
        runUntilPc(12'h102);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'h200);
        runUntilPc(12'h201);

        applyStimulus(1'b0, 1'b0, 1'b1, 12'd20);
        runUntilPc(12'd20);
        checkOutput("addi_opcode", {27'd0, opcode}, 32'h05);
        checkOutput("addi_rd", {27'd0, rd}, 32'd3);
        checkOutput("addi_rs", {27'd0, rs}, 32'd2);
        checkOutput("addi_imm", imm_sext, 32'd7);
        runUntilPc(12'd21);
        checkOutput("neg_imm", imm_sext, 32'hFFFF_FFFF);

        applyStimulus(1'b0, 1'b0, 1'b1, 12'd4094);
        runUntilPc(12'd4094);
        checkOutput("wrap_imem_addr", {20'd0, imem_addr}, 32'd0);
        runUntilPc(12'd4095);
        checkOutput("wrap_pc_plus1", {20'd0, pc_plus1}, 32'd0);
        runUntilPc(12'd1);

        // Asynchronous reset in the middle of a stall cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 12'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_stall_valid", {31'd0, insn_valid}, 32'd0);
        checkOutput("async_stall_instr", instr, 32'd0);
        checkOutput("async_stall_pc", {20'd0, pc_out}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
        runUntilPc(12'd3);

        // Asynchronous reset while a redirect is being presented.
        applyStimulus(1'b0, 1'b0, 1'b1, 12'h300);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_redir_valid", {31'd0, insn_valid}, 32'd0);
        checkOutput("async_redir_addr", {20'd0, imem_addr}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'd0);
        runUntilPc(12'd2);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            applyStimulus(1'b0, r < 25, r >= 92, 12'($urandom_range(0, 4095)));
        end
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 12'd0);
        @(posedge clock); #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the processor control decoder.
- Owns the PC and drives the synchronous instruction ROM (1-cycle read latency).
- Registers the returned word into an instruction register, then splits it into opcode, func and register/immediate fields that feed the control decoder and the register file.
- Supports downstream stall and taken-branch/jump redirect with wrong-path squash.

Parameters:
- PC_WIDTH, 12, PC and imem address width (4096-word ROM).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  downstream cannot accept; hold current instruction.
- redirect  in  1  branch/jump taken; refetch from redirect_pc.
- redirect_pc  in  PC_WIDTH  redirect target.
- imem_addr  out  PC_WIDTH  ROM address (combinational).
- imem_q  in  32  ROM data; word addressed on the previous cycle.
- insn_valid  out  1  instr/fields hold a real instruction.
- instr  out  32  instruction register.
- pc_out  out  PC_WIDTH  address of instr.
- pc_plus1  out  PC_WIDTH  pc_out+1, wraps modulo 2^PC_WIDTH.
- opcode  out  5  instr[31:27].
- rd  out  5  instr[26:22].
- rs  out  5  instr[21:17].
- rt  out  5  instr[16:12].
- shamt  out  5  instr[11:7].
- alu_in  out  5  instr[6:2] (func).
- imm_sext  out  32  instr[16:0] sign-extended.

Behaviour:
- State regs:
  - pc_q: next address to issue.
  - fa_q: address issued last cycle.
  - fv_q: last issue is real, not squashed.
  - instr_q, pcout_q, valid_q.
- Reset (async, any cycle, mid-operation included):
  - pc_q=RESET_PC, fa_q=RESET_PC, fv_q=0, valid_q=0, instr_q=0, pcout_q=0.
  - All field outputs therefore read 0.
- imem_addr = stall&&!redirect ? fa_q : pc_q.
  - During stall the ROM re-reads the in-flight word, so no skid buffer is needed.
- Normal cycle (stall=0, redirect=0):
  - instr_q<=imem_q, pcout_q<=fa_q, valid_q<=fv_q.
  - fa_q<=pc_q, fv_q<=1, pc_q<=pc_q+1 (wraps 4095->0).
- Stall (stall=1, redirect=0):
  - instr_q, pcout_q, valid_q, pc_q, fa_q, fv_q all hold.
  - Stall while valid_q=0 also holds (harmless bubble).
- Redirect (redirect=1; overrides stall):
  - valid_q<=0 (squash the decoded instruction; downstream has consumed the branch).
  - fv_q<=0 (squash the wrong-path word arriving next cycle).
  - fa_q<=pc_q.
  - pc_q<=redirect_pc.
  - Next cycle imem_addr=redirect_pc.
- Latencies:
  - Reset deassert in cycle 0 -> instr at RESET_PC valid from cycle 2.
  - Redirect in cycle N -> target valid in cycle N+3.
  - Steady state: one instruction per cycle.
- Back-to-back redirects: the later target wins; every intermediate word is squashed.
- Output fields are combinational slices of instr_q. imm_sext = {{15{instr_q[16]}}, instr_q[16:0]}.
- FSM (derived from fv_q/valid_q for coverage):
  - FILL: after reset/redirect, valid_q=0.
  - RUN.
  - HOLD: stall with valid_q=1.
  - Transitions:
    - FILL->RUN after two non-stall cycles.
    - RUN<->HOLD on stall.
    - Any state->FILL on redirect or reset.

Decomposition:
- Shared package proc_defs (also consumed by control):
  - Opcode constants: OP_RTYPE=5'b00000, OP_ADDI=5'b00101, OP_SW=5'b00111, OP_LW=5'b01000.
  - Func constants: ADD/SUB/AND/OR/SLL/SRA = 0..5.
  - Field bit positions; PC_WIDTH default.
- One sub-module, insn_fields: pure combinational slicer/sign-extender of a 32-bit word, reused by later stages.

Test Plan:
- Reset then run with ROM mem[i]=i*0x11 and no stall -> insn_valid=0 for cycles 0-1; cycle 2 instr=0, pc_out=0; cycle 3 instr=0x11, pc_out=1; one instruction per cycle thereafter.
- Word 0x28C40007 (addi, rd=3, rs=2, imm=7) -> opcode=00101, rd=3, rs=2, imm_sext=7. Word with instr[16]=1, imm=0x1FFFF -> imm_sext=0xFFFFFFFF.
- stall high 3 cycles while pc_out=5 -> instr/pc_out frozen at word 5, imem_addr=6 held; after release, pc_out 6,7,8 with none skipped or duplicated.
- redirect to 0x100 at pc_out=10 -> next 2 cycles insn_valid=0, then pc_out=0x100, 0x101. Redirect with stall=1 in the same cycle -> identical result.
- PC at 4095 -> pc_plus1=0; next fetch address 0.
- Assert reset asynchronously mid-stall and mid-redirect -> outputs clear immediately without a clock edge; refetch starts at RESET_PC.
